// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART framing constants and helpers for the receive controller.
package uart_rx_ctrl_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_FRAME_BITS = 10;
   localparam int UART_DATA_W     = 8;
   localparam int IDLE_FRAMES     = 4;

   // Oversample ticks spanning a given number of whole frames.
   function automatic int idle_ticks_for(input int frames);
      return frames * UART_FRAME_BITS * UART_OVERSAMPLE;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset; contents are only visible while non-empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Pointer and occupancy registers, synchronously cleared.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick generator, byte capture on the
// receiver's ready edge, byte FIFO with stream output, overrun and idle flags.
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int IDLE_TICKS = idle_ticks_for(IDLE_FRAMES)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rx_enable,
   input  logic [15:0]              baud_div,
   output logic                     clk_en,
   output logic                     rx_rst,
   input  logic                     rx_ready,
   input  logic [UART_DATA_W-1:0]   rx_data,
   output logic [UART_DATA_W-1:0]   m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overrun,
   input  logic                     clr_overrun,
   output logic                     idle_timeout
);

   localparam int IW = $clog2(IDLE_TICKS + 1);

   logic [15:0]            div_cnt_q, div_cnt_d;
   logic                   clk_en_q, clk_en_d;
   logic                   rdy_q, rdy_d;
   logic                   overrun_q, overrun_d;
   logic [IW-1:0]          idle_left_q, idle_left_d;
   logic                   idle_timeout_q, idle_timeout_d;

   logic                   push, pop, drop;
   logic [UART_DATA_W-1:0] fifo_dout;
   logic                   fifo_full, fifo_empty;

   assign push = rx_ready & ~rdy_q;
   assign pop  = m_ready & ~fifo_empty;
   assign drop = push & fifo_full & ~pop;

   uart_sync_fifo #(
      .WIDTH (UART_DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (rx_data),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign clk_en       = clk_en_q;
   assign rx_rst       = ~reset;
   assign m_valid      = ~fifo_empty;
   assign m_data       = fifo_empty ? '0 : fifo_dout;
   assign overrun      = overrun_q;
   assign idle_timeout = idle_timeout_q;

   // Baud divider; '>=' lets a lowered divisor take effect without wrapping.
   always_comb begin
      div_cnt_d = div_cnt_q;
      clk_en_d  = 1'b0;
      if (!rx_enable) begin
         div_cnt_d = '0;
      end else if (div_cnt_q >= baud_div) begin
         div_cnt_d = '0;
         clk_en_d  = 1'b1;
      end else begin
         div_cnt_d = div_cnt_q + 16'd1;
      end
   end

   // Edge capture and sticky overrun; a new drop outranks a clear.
   always_comb begin
      rdy_d     = rx_ready;
      overrun_d = drop | (overrun_q & ~clr_overrun);
   end

   // Idle timer counts down ticks since the last push; disarmed while empty.
   always_comb begin
      idle_left_d    = idle_left_q;
      idle_timeout_d = 1'b0;
      if (push) begin
         idle_left_d = IW'(IDLE_TICKS);
      end else if (fifo_empty) begin
         idle_left_d = '0;
      end else if (clk_en_q && (idle_left_q != '0)) begin
         idle_left_d = idle_left_q - IW'(1);
         if (idle_left_q == IW'(1)) begin
            idle_timeout_d = 1'b1;
         end
      end
   end

   // Control registers; ready history resets high so a stale ready is ignored.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_cnt_q      <= '0;
         clk_en_q       <= 1'b0;
         rdy_q          <= 1'b1;
         overrun_q      <= 1'b0;
         idle_left_q    <= '0;
         idle_timeout_q <= 1'b0;
      end else begin
         div_cnt_q      <= div_cnt_d;
         clk_en_q       <= clk_en_d;
         rdy_q          <= rdy_d;
         overrun_q      <= overrun_d;
         idle_left_q    <= idle_left_d;
         idle_timeout_q <= idle_timeout_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed divider/idle/reset checks plus a random
// byte stream scored against a queue-based model of the buffered bytes.
module tb_uart_rx_ctrl;

   localparam int DEPTH      = 8;
   localparam int IDLE_TICKS = 4 * 10 * 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_enable;
   logic [15:0] baud_div;
   logic        clk_en;
   logic        rx_rst;
   logic        rx_ready;
   logic [7:0]  rx_data;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic [3:0]  fifo_count;
   logic        overrun;
   logic        clr_overrun;
   logic        idle_timeout;

   int total = 0;
   int bad   = 0;

   // Reference model: bytes the FIFO should hold, oldest first.
   logic [7:0] exp_q[$];
   int         occ;
   logic       exp_ovr;
   logic       prev_rdy;

   always #5 clk = ~clk;

   uart_rx_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .rx_enable    (rx_enable),
      .baud_div     (baud_div),
      .clk_en       (clk_en),
      .rx_rst       (rx_rst),
      .rx_ready     (rx_ready),
      .rx_data      (rx_data),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .fifo_count   (fifo_count),
      .overrun      (overrun),
      .clr_overrun  (clr_overrun),
      .idle_timeout (idle_timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every accepted output byte must be the oldest expected one.
   always @(negedge clk) begin
      if (reset === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_extra: got %0h expected no byte at %0t", m_data, $time);
         end else begin
            check("sb_data", m_data, exp_q.pop_front());
         end
      end
   end

   // Called at posedge+1: compare state, apply inputs, advance model over the next edge.
   task automatic step(input logic rdy, input logic [7:0] d, input logic mr, input logic clr);
      logic push, pop, dropped;
      check("count", fifo_count, occ);
      check("valid", m_valid, occ > 0);
      check("head", m_data, (occ > 0) ? exp_q[0] : 8'h00);
      check("overrun", overrun, exp_ovr);
      rx_ready    = rdy;
      rx_data     = d;
      m_ready     = mr;
      clr_overrun = clr;
      push    = rdy & ~prev_rdy;
      pop     = mr && (occ > 0);
      dropped = 1'b0;
      if (push) begin
         if (occ == DEPTH && !pop) dropped = 1'b1;
         else begin
            exp_q.push_back(d);
            occ++;
         end
      end
      if (pop) occ--;
      if (dropped) exp_ovr = 1'b1;
      else if (clr) exp_ovr = 1'b0;
      prev_rdy = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic mr);
      step(1'b1, b, mr, 1'b0);
      step(1'b1, b, 1'b0, 1'b0);
      step(1'b0, b, 1'b0, 1'b0);
   endtask

   task automatic tick(input logic exp_en, input string name);
      @(posedge clk);
      #1;
      check(name, clk_en, exp_en);
   endtask

   initial begin
      int mr_pct;
      reset       = 1'b0;
      rx_enable   = 1'b0;
      baud_div    = 16'd3;
      rx_ready    = 1'b0;
      rx_data     = 8'h00;
      m_ready     = 1'b0;
      clr_overrun = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_clk_en", clk_en, 0);
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_count", fifo_count, 0);
      check("rst_overrun", overrun, 0);
      check("rst_idle", idle_timeout, 0);
      check("rst_rx_rst", rx_rst, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("run_rx_rst", rx_rst, 0);

      // Divider: period baud_div+1, first tick baud_div+1 edges after enable.
      rx_enable = 1'b1;
      for (int i = 0; i < 16; i++) tick((i % 4) == 3, "div3");
      rx_enable = 1'b0;
      for (int i = 0; i < 8; i++) tick(1'b0, "div_off");
      baud_div  = 16'd0;
      rx_enable = 1'b1;
      for (int i = 0; i < 5; i++) tick(1'b1, "div0");
      rx_enable = 1'b0;
      tick(1'b0, "div_off0");
      baud_div  = 16'd100;
      rx_enable = 1'b1;
      for (int i = 0; i < 10; i++) tick(1'b0, "div100");
      baud_div = 16'd5;
      tick(1'b1, "div_lowered");
      for (int i = 0; i < 12; i++) tick((i % 6) == 5, "div5");
      rx_enable = 1'b0;
      @(posedge clk);
      #1;

      occ      = 0;
      exp_ovr  = 1'b0;
      prev_rdy = rx_ready;

      // Single frame.
      send_byte(8'hA5, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Fill past full; the overflowing push coincides with a clear request.
      for (int b = 0; b < 8; b++) send_byte(8'(b), 1'b0);
      step(1'b1, 8'h08, 1'b0, 1'b1);
      step(1'b1, 8'h08, 1'b0, 1'b0);
      step(1'b0, 8'h08, 1'b0, 1'b0);
      repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Full FIFO with push and pop on the same edge.
      for (int b = 0; b < 8; b++) send_byte(8'(8'h10 + b), 1'b0);
      step(1'b1, 8'h99, 1'b1, 1'b0);
      step(1'b1, 8'h99, 1'b0, 1'b0);
      step(1'b0, 8'h99, 1'b0, 1'b0);
      repeat (9) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic with varying consumer throttling.
      mr_pct = 50;
      for (int i = 0; i < 600; i++) begin
         if ((i % 64) == 0) mr_pct = (($urandom_range(0, 2)) * 40) + 10;
         step($urandom_range(0, 2) == 0, 8'($urandom),
              $urandom_range(0, 99) < mr_pct, $urandom_range(0, 31) == 0);
      end
      repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Idle timeout: one tick per cycle, single pulse at the IDLE_TICKS-th tick.
      baud_div  = 16'd0;
      rx_enable = 1'b1;
      repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      for (int k = 1; k <= IDLE_TICKS + 60; k++) begin
         step(1'b0, 8'h3C, 1'b0, 1'b0);
         check("idle_pulse", idle_timeout, k == IDLE_TICKS);
      end

      // Reset mid-frame with three bytes buffered.
      step(1'b1, 8'h41, 1'b0, 1'b0);
      step(1'b0, 8'h41, 1'b0, 1'b0);
      step(1'b1, 8'h42, 1'b0, 1'b0);
      step(1'b0, 8'h42, 1'b0, 1'b0);
      check("pre_rst_count", fifo_count, 3);
      rx_ready = 1'b1;
      rx_data  = 8'h77;
      reset    = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_valid", m_valid, 0);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_clk_en", clk_en, 0);
      check("mid_rst_rx_rst", rx_rst, 1);
      check("mid_rst_data", m_data, 0);
      exp_q.delete();
      occ      = 0;
      exp_ovr  = 1'b0;
      prev_rdy = 1'b1;
      reset    = 1'b1;
      repeat (3) step(1'b1, 8'h77, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      send_byte(8'h5A, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
